// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and per-core status codes.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT_RD = 2'b10,
    ST_RESP    = 2'b11
  } arb_state_e;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_WAIT = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;

endpackage

// File: rtl/dm_arbiter_rr_select.sv
// Combinational round-robin priority encoder: first requester at or after rr, wrapping upward.
module rr_select #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     rr,
  output logic [IDX_W-1:0]     grant,
  output logic                 valid
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx   = (int'(rr) + k) % NUM_CORES;
      valid = valid | req[idx];
      grant = req[idx] ? IDX_W'(idx) : grant;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_CORES cores.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                        clock,
  input  logic                        rst_r,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES*2-1:0]      status,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int         IDX_W    = $clog2(NUM_CORES);
  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    lat_we_q, lat_we_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [NUM_CORES*2-1:0]  status_q, status_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    busy_q, busy_d;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_valid;

  rr_select #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req   (req),
    .rr    (rr_q),
    .grant (sel_idx),
    .valid (sel_valid)
  );

  // Next-state and next-output computation; mem_addr/mem_wdata double as the grant latch.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    lat_we_d    = lat_we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d     = ST_ISSUE;
          grant_d     = sel_idx;
          lat_we_d    = we[sel_idx];
          mem_addr_d  = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[int'(sel_idx)*DATA_W +: DATA_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (lat_we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT_RD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT_RD: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        rr_d    = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ISSUE is always entered from IDLE, so the strobe can never repeat back to back.
    mem_en_d = (state_d == ST_ISSUE);
    mem_we_d = mem_en_d & lat_we_d;
    busy_d   = (state_d != ST_IDLE);
    status_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      status_d[2*i +: 2] = ((state_d == ST_RESP) && (grant_d == IDX_W'(i))) ? STAT_DONE :
                           (req[i] ? STAT_WAIT : STAT_IDLE);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_r) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      lat_we_q    <= 1'b0;
      cnt_q       <= 2'd0;
      status_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      lat_we_q    <= lat_we_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign status    = status_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: table vectors, corner-case sequences and random rounds against a grant-order model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct {
    int          core;
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  rd;
  } vec_t;

  logic clock = 1'b0;
  logic rst_r;
  logic mem_init;

  logic [N-1:0]    req_a, we_a, req_b, we_b;
  logic [N*AW-1:0] addr_a, addr_b;
  logic [N*DW-1:0] wdata_a, wdata_b;
  logic [2*N-1:0]  status_a, status_b;
  logic [DW-1:0]   rdata_a, rdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b, rd_b1;
  logic [AW-1:0]   mem_addr_a, mem_addr_b;
  logic            mem_en_a, mem_we_a, busy_a, mem_en_b, mem_we_b, busy_b;

  logic [7:0] mem_a  [0:255];
  logic [7:0] mem_b  [0:255];
  logic [7:0] shadow [0:255];

  int       total, bad;
  int       rr_m;
  logic [N-1:0] pend;

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .clock(clock), .rst_r(rst_r), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .status(status_a), .rdata(rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut_b (
    .clock(clock), .rst_r(rst_r), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .status(status_b), .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h40) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return shadow[a[7:0]];
  endfunction

  // Memory for the RD_LAT=1 instance.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_val(8'(i));
    end else if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    end else if (mem_en_a) begin
      mem_rdata_a <= mem_a[mem_addr_a[7:0]];
    end
  end

  // Memory for the RD_LAT=2 instance: one extra output pipeline stage.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_val(8'(i));
    end else if (mem_en_b && mem_we_b) begin
      mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
    end else if (mem_en_b) begin
      rd_b1 <= mem_b[mem_addr_b[7:0]];
    end
    mem_rdata_b <= rd_b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_a(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
    we_a[c]               = w;
    addr_a[c*AW +: AW]    = a;
    wdata_a[c*DW +: DW]   = d;
    req_a[c]              = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_a && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (busy_a) chk("idle_timeout", 32'(busy_a), 32'd0);
  endtask

  // Model: next winner is the first pending core at or after the model's rr pointer.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic run_round(input int max_grants, input logic [N-1:0] hold);
    int grants, cyc, w, dc;
    logic prev_en;
    logic [15:0] a;
    grants  = 0;
    cyc     = 0;
    prev_en = 1'b0;
    while (pend != '0 && cyc < 300) begin
      @(negedge clock);
      cyc++;
      chk("single_port", 32'(prev_en & mem_en_a), 32'd0);
      prev_en = mem_en_a;
      dc = -1;
      for (int c = 0; c < N; c++) begin
        if (status_a[2*c +: 2] == STAT_DONE) dc = c;
        else chk("req_status", 32'(status_a[2*c +: 2]), req_a[c] ? 32'(STAT_WAIT) : 32'(STAT_IDLE));
      end
      if (dc >= 0) begin
        w = model_winner();
        chk("grant_order", dc, w);
        a = addr_a[dc*AW +: AW];
        if (we_a[dc]) shadow[a[7:0]] = wdata_a[dc*DW +: DW];
        else chk("rd_data", 32'(rdata_a), 32'(sh_rd(a)));
        grants++;
        if (w >= 0) begin
          rr_m = (w + 1) % N;
          if (!hold[w]) pend[w] = 1'b0;
        end
        if (!hold[dc]) req_a[dc] = 1'b0;
        if (grants == max_grants) begin
          req_a = '0;
          pend  = '0;
        end
      end
    end
    chk("round_complete", 32'(pend), 32'd0);
  endtask

  initial begin : main
    vec_t        tbl [6];
    int          n, en_cnt;
    logic        done_f;
    logic [15:0] a;

    total = 0; bad = 0; rr_m = 0; pend = '0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    rst_r = 1'b0; mem_init = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));

    tbl[0] = '{2, 1'b0, 16'h0040, 8'h00, 3, 8'hA5};
    tbl[1] = '{0, 1'b1, 16'h0010, 8'h3C, 2, 8'h00};
    tbl[2] = '{0, 1'b0, 16'h0010, 8'h00, 3, 8'h3C};
    tbl[3] = '{3, 1'b1, 16'hBEEF, 8'h77, 2, 8'h00};
    tbl[4] = '{1, 1'b0, 16'hBEEF, 8'h00, 3, 8'h77};
    tbl[5] = '{1, 1'b0, 16'h1234, 8'h00, 3, 8'h6E};

    repeat (3) @(negedge clock);
    mem_init = 1'b0;
    chk("rst_status", 32'(status_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_mem_en", 32'(mem_en_a), 32'd0);
    chk("rst_mem_we", 32'(mem_we_a), 32'd0);
    chk("rst_rdata", 32'(rdata_a), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
    chk("rst_status_b", 32'(status_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst_r = 1'b1;

    for (int v = 0; v < 6; v++) begin
      wait_idle();
      set_a(tbl[v].core, tbl[v].w, tbl[v].a, tbl[v].d);
      n = 0; en_cnt = 0; done_f = 1'b0;
      while (!done_f && n < 10) begin
        @(negedge clock);
        n++;
        if (mem_en_a) begin
          en_cnt++;
          chk("vec_en_cycle", n, 1);
          chk("vec_mem_we", 32'(mem_we_a), 32'(tbl[v].w));
          chk("vec_mem_addr", 32'(mem_addr_a), 32'(tbl[v].a));
          if (tbl[v].w) chk("vec_mem_wdata", 32'(mem_wdata_a), 32'(tbl[v].d));
        end
        if (status_a[2*tbl[v].core +: 2] == STAT_DONE) done_f = 1'b1;
        else chk("vec_wait", 32'(status_a[2*tbl[v].core +: 2]), 32'(STAT_WAIT));
      end
      chk("vec_latency", n, tbl[v].lat);
      chk("vec_en_count", en_cnt, 1);
      if (!tbl[v].w) chk("vec_rdata", 32'(rdata_a), 32'(tbl[v].rd));
      else shadow[tbl[v].a[7:0]] = tbl[v].d;
      req_a = '0;
      @(negedge clock);
      chk("vec_release", 32'(status_a[2*tbl[v].core +: 2]), 32'(STAT_IDLE));
    end

    // Dropping req and changing addr while granted must not affect the access.
    wait_idle();
    set_a(0, 1'b0, 16'h0055, 8'h00);
    @(negedge clock);
    chk("drop_issue_en", 32'(mem_en_a), 32'd1);
    req_a[0] = 1'b0;
    addr_a[0 +: AW] = 16'h0040;
    @(negedge clock);
    chk("drop_status_idle", 32'(status_a[1:0]), 32'(STAT_IDLE));
    chk("drop_busy", 32'(busy_a), 32'd1);
    @(negedge clock);
    chk("drop_done", 32'(status_a[1:0]), 32'(STAT_DONE));
    chk("drop_rdata", 32'(rdata_a), 32'(sh_rd(16'h0055)));
    @(negedge clock);
    chk("drop_release", 32'(status_a[1:0]), 32'(STAT_IDLE));

    // Reset during WAIT_RD abandons the access.
    wait_idle();
    set_a(2, 1'b0, 16'h0040, 8'h00);
    repeat (2) @(negedge clock);
    chk("rst_mid_busy", 32'(busy_a), 32'd1);
    rst_r = 1'b0;
    @(negedge clock);
    chk("rst_mid_status", 32'(status_a), 32'd0);
    chk("rst_mid_busy0", 32'(busy_a), 32'd0);
    chk("rst_mid_mem_en", 32'(mem_en_a), 32'd0);
    chk("rst_mid_rdata", 32'(rdata_a), 32'd0);
    req_a = '0;
    rst_r = 1'b1;
    rr_m  = 0;

    // All cores read together: order must start from a reset rr of 0.
    @(negedge clock);
    pend = '1;
    for (int c = 0; c < N; c++) set_a(c, 1'b0, 16'h0100 + 16'(c), 8'h00);
    run_round(N, '0);
    wait_idle();

    // Cores 1 and 3 keep requesting: they must alternate.
    pend = 4'b1010;
    set_a(1, 1'b0, 16'h0020, 8'h00);
    set_a(3, 1'b1, 16'h0021, 8'h99);
    run_round(4, 4'b1010);
    wait_idle();

    for (int r = 0; r < 40; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) begin
        if (pend[c]) set_a(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
      end
      run_round(N, '0);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // RD_LAT=2 instance: reads complete four cycles after req.
    for (int v = 0; v < 2; v++) begin
      a = (v == 0) ? 16'h0040 : 16'h0077;
      we_b[2] = 1'b0;
      addr_b[2*AW +: AW] = a;
      req_b[2] = 1'b1;
      n = 0; en_cnt = 0; done_f = 1'b0;
      while (!done_f && n < 12) begin
        @(negedge clock);
        n++;
        if (mem_en_b) begin
          en_cnt++;
          chk("b_en_cycle", n, 1);
          chk("b_mem_addr", 32'(mem_addr_b), 32'(a));
        end
        if (status_b[5:4] == STAT_DONE) done_f = 1'b1;
        else chk("b_wait", 32'(status_b[5:4]), 32'(STAT_WAIT));
      end
      chk("b_latency", n, 4);
      chk("b_en_count", en_cnt, 1);
      chk("b_rdata", 32'(rdata_b), 32'(init_val(a[7:0])));
      req_b[2] = 1'b0;
      @(negedge clock);
      chk("b_release", 32'(status_b[5:4]), 32'(STAT_IDLE));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
